shared_multiplier_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one shift-add unsigned multiplier datapath among NREQ requesters. Each requester presents an operand pair with a request. The block grants one request at a time and runs the WIDTH-cycle multiply. It then returns the product with a one-hot completion pulse. It sits between several client blocks and the single multiplier resource, so clients never contend for the datapath directly.

---
 rtl/shared_multiplier_arbiter_if.sv | 15 +
 rtl/shared_multiplier_arbiter.sv | 89 ++++++++
 tb/tb_shared_multiplier_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_multiplier_arbiter_if.sv
// shared_multiplier_arbiter_if: request/operand/result bundle between clients and the shared multiplier
interface shared_multiplier_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] ina;
    logic [NREQ*WIDTH-1:0] inb;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [2*WIDTH-1:0]    out;
    logic                  busy;
    modport master (output req, ina, inb, input gnt, done, out, busy);
    modport slave  (input req, ina, inb, output gnt, done, out, busy);
endinterface

// File: rtl/shared_multiplier_arbiter.sv
// shared_multiplier_arbiter: round-robin sharing of one shift-add multiplier among NREQ requesters
module shared_multiplier_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    shared_multiplier_arbiter_if.slave  io_bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [PW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;
    logic [NREQ-1:0]    r_sel;
    logic [NREQ-1:0]    r_gnt;
    logic [NREQ-1:0]    r_done;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_out;
    logic [PW-1:0]      w_win;
    logic               w_any;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [NREQ-1:0]    w_win_oh;

    // Descending scan so the lowest offset from r_ptr is the last (winning) assignment
    always_comb begin
        w_any = |io_bus.req;
        w_win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (io_bus.req[(int'(r_ptr) + i) % NREQ]) w_win = PW'((int'(r_ptr) + i) % NREQ);
        end
    end

    assign w_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_out   <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_sel   <= w_win_oh;
                    r_gnt   <= w_win_oh;
                    r_mcand <= {{WIDTH{1'b0}}, io_bus.ina[int'(w_win)*WIDTH +: WIDTH]};
                    r_mplr  <= io_bus.inb[int'(w_win)*WIDTH +: WIDTH];
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_ptr   <= (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    r_state <= S_MUL;
                end
            end else if (r_state == S_MUL) begin
                r_acc   <= w_acc_nxt;
                r_mcand <= r_mcand << 1;
                r_mplr  <= r_mplr >> 1;
                r_cnt   <= r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_out   <= w_acc_nxt;
                    r_done  <= r_sel;
                    r_state <= S_DONE;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    assign io_bus.gnt  = r_gnt;
    assign io_bus.done = r_done;
    assign io_bus.out  = r_out;
    assign io_bus.busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_shared_multiplier_arbiter.sv
// tb_shared_multiplier_arbiter: scoreboard bench with a transaction-level arbitration model
module tb_shared_multiplier_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        int id;
        int cyc;
        int prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_multiplier_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();
    shared_multiplier_arbiter #(.WIDTH(W), .NREQ(N)) dut (.clk(clk), .rst(rst), .io_bus(bus));

    exp_t gq[$];
    exp_t dq[$];
    int   glog_v[$];
    int   glog_c[$];
    int   dlog_c[$];
    int   cyc = 0;
    int   m_ptr = 0;
    int   m_wait = 0;
    int   m_out = 0;
    int   mk, ma, mb;
    int   last_out = -1;
    int   last_done = -1;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [N-1:0] oh(int k);
        logic [N-1:0] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one service per W+2 cycles, round-robin from a pointer, exact product
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                gq.delete();
                dq.delete();
                m_ptr = 0;
                m_wait = 0;
                m_out = 0;
            end else if (m_wait == 0 && bus.req != '0) begin
                mk = -1;
                for (int i = N - 1; i >= 0; i--) if (bus.req[(m_ptr + i) % N]) mk = (m_ptr + i) % N;
                ma = int'(bus.ina[mk*W +: W]);
                mb = int'(bus.inb[mk*W +: W]);
                gq.push_back('{mk, cyc, 0});
                dq.push_back('{mk, cyc + W, ma * mb});
                m_ptr = (mk + 1) % N;
                m_wait = W + 1;
            end else if (m_wait > 0) begin
                m_wait--;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents gnt/done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                glog_v.push_back(int'(bus.gnt));
                glog_c.push_back(cyc);
                if (gq.size() == 0) chk("gnt_spurious", longint'(bus.gnt), 0);
                else begin
                    e = gq.pop_front();
                    chk("gnt_id", longint'(bus.gnt), longint'(oh(e.id)));
                    chk("gnt_cycle", cyc, e.cyc);
                end
            end else if (gq.size() != 0 && gq[0].cyc < cyc) begin
                chk("gnt_missing", longint'(bus.gnt), longint'(oh(gq[0].id)));
                void'(gq.pop_front());
            end
            if (bus.done != '0) begin
                dlog_c.push_back(cyc);
                last_done = int'(bus.done);
                last_out = int'(bus.out);
                if (dq.size() == 0) chk("done_spurious", longint'(bus.done), 0);
                else begin
                    e = dq.pop_front();
                    chk("done_id", longint'(bus.done), longint'(oh(e.id)));
                    chk("done_cycle", cyc, e.cyc);
                    chk("out", longint'(bus.out), e.prod);
                    m_out = e.prod;
                end
            end else begin
                if (dq.size() != 0 && dq[0].cyc < cyc) begin
                    chk("done_missing", longint'(bus.done), longint'(oh(dq[0].id)));
                    void'(dq.pop_front());
                end
                chk("out_hold", longint'(bus.out), m_out);
            end
            chk("busy", longint'(bus.busy), longint'(m_wait != 0));
        end
    end

    task automatic op(int id, int a, int b);
        @(negedge clk);
        bus.req = '0;
        bus.req[id] = 1'b1;
        bus.ina[id*W +: W] = W'(a);
        bus.inb[id*W +: W] = W'(b);
        @(negedge clk);
        bus.req = '0;
        repeat (11) @(negedge clk);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 1;
            2: return 255;
            3: return 128;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int g0, d0;
        int fo[6] = '{1, 2, 4, 8, 1, 4};
        bus.req = '0;
        bus.ina = '0;
        bus.inb = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", longint'(bus.gnt), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_out", longint'(bus.out), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        rst = 1'b0;

        op(0, 13, 11);
        chk("single_out", last_out, 143);
        chk("single_done", last_done, 1);
        op(0, 255, 255);
        chk("max_out", last_out, 65025);
        op(1, 0, 200);
        chk("zero_out", last_out, 0);
        op(2, 1, 255);
        chk("one_out", last_out, 255);
        op(3, 128, 2);
        chk("carry_out", last_out, 256);

        // All four requesters held: grants 0,1,2,3,0 then ptr=1 with req=0101 picks 2
        g0 = glog_v.size();
        @(negedge clk);
        bus.req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.ina[i*W +: W] = W'(10 + i);
            bus.inb[i*W +: W] = W'(20 + 3 * i);
        end
        repeat (41) @(negedge clk);
        bus.req = '0;
        repeat (12) @(negedge clk);
        bus.req = 4'b0101;
        @(negedge clk);
        bus.req = '0;
        repeat (12) @(negedge clk);
        chk("fair_count", glog_v.size() - g0, 6);
        for (int i = 0; i < 6 && g0 + i < glog_v.size(); i++) chk("fair_order", glog_v[g0+i], fo[i]);
        for (int i = 0; i < 4 && g0 + i + 1 < glog_c.size(); i++) chk("fair_gap", glog_c[g0+i+1] - glog_c[g0+i], 10);

        // Operand changes during MUL must not affect the result
        @(negedge clk);
        bus.req = 4'b0001;
        bus.ina[0 +: W] = 8'd50;
        bus.inb[0 +: W] = 8'd60;
        @(negedge clk);
        bus.req = '0;
        bus.ina[0 +: W] = 8'd3;
        bus.inb[0 +: W] = 8'd4;
        repeat (3) @(negedge clk);
        bus.ina[0 +: W] = 8'd200;
        repeat (8) @(negedge clk);
        chk("stable_out", last_out, 3000);

        // Reset sampled at E0+4 aborts the operation
        d0 = dlog_c.size();
        @(negedge clk);
        bus.req = 4'b0001;
        bus.ina[0 +: W] = 8'd100;
        bus.inb[0 +: W] = 8'd100;
        @(negedge clk);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_gnt", longint'(bus.gnt), 0);
        chk("abort_done", longint'(bus.done), 0);
        chk("abort_out", longint'(bus.out), 0);
        chk("abort_busy", longint'(bus.busy), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_no_done", dlog_c.size() - d0, 0);
        op(1, 7, 9);
        chk("post_rst_out", last_out, 63);
        chk("post_rst_done", last_done, 2);

        // Continuous single requester
        g0 = glog_c.size();
        d0 = dlog_c.size();
        @(negedge clk);
        bus.req = 4'b1000;
        bus.ina[3*W +: W] = 8'd17;
        bus.inb[3*W +: W] = 8'd19;
        repeat (31) @(negedge clk);
        bus.req = '0;
        repeat (12) @(negedge clk);
        chk("cont_count", glog_c.size() - g0, 4);
        for (int i = 0; i < 3 && g0 + i + 1 < glog_c.size(); i++) begin
            chk("cont_gap", glog_c[g0+i+1] - glog_c[g0+i], 10);
            if (d0 + i < dlog_c.size()) chk("cont_done_lead", glog_c[g0+i+1] - dlog_c[d0+i], 2);
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.ina[i*W +: W] = W'(pick());
                    bus.inb[i*W +: W] = W'(pick());
                end
            end
        end
        bus.req = '0;
        repeat (14) @(negedge clk);
        chk("gq_drained", gq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
